// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 1 bit per cycle, fixed latency.
// Shift-add multiply and restoring divide on operand magnitudes.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   reset   - asynchronous active-high reset
//   start   - request a new operation (taken only when idle)
//   funct3  - MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU select
//   dataA   - rs1 operand
//   dataB   - rs2 operand
//   rd      - destination register of the request
//   busy    - high from the accepting edge until the result cycle ends
//   done    - one-cycle completion pulse
//   RegWEn  - register-file write enable (suppressed for rd == 0)
//   addrD   - latched destination register
//   dataD   - result
module muldiv_unit #(
    parameter int REG_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2:0]                funct3,
    input  logic [REG_WIDTH-1:0]      dataA,
    input  logic [REG_WIDTH-1:0]      dataB,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      busy,
    output logic                      done,
    output logic                      RegWEn,
    output logic [REG_ADDR_WIDTH-1:0] addrD,
    output logic [REG_WIDTH-1:0]      dataD
);

    localparam int W  = REG_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]                r_op;
    logic [W-1:0]              r_a;
    logic [W-1:0]              r_b;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [CW-1:0]             r_cnt;
    logic [2*W-1:0]            r_acc;

    logic                      r_busy;
    logic                      r_done;
    logic                      r_wen;
    logic [REG_ADDR_WIDTH-1:0] r_addrD;
    logic [W-1:0]              r_dataD;

    logic           w_a_signed;
    logic           w_b_signed;
    logic           w_neg_a;
    logic           w_neg_b;
    logic           w_is_div;
    logic           w_b_zero;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic [2*W-1:0] w_acc;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_mul_nxt;
    logic [W:0]     w_rs;
    logic           w_ge;
    logic [2*W-1:0] w_div_nxt;
    logic [2*W-1:0] w_acc_nxt;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_result;

    // Operand signedness from the latched op
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (r_op)
            F_MUL, F_MULH, F_DIV, F_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            F_MULHSU: w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_neg_a  = w_a_signed & r_a[W-1];
    assign w_neg_b  = w_b_signed & r_b[W-1];
    assign w_mag_a  = w_neg_a ? -r_a : r_a;
    assign w_mag_b  = w_neg_b ? -r_b : r_b;
    assign w_is_div = r_op[2];
    assign w_b_zero = (r_b == '0);

    // Iteration 0 seeds the accumulator from the latched operands:
    // multiply keeps the multiplier in the low half, divide the dividend.
    assign w_acc = (r_cnt == '0)
                 ? {{W{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)}
                 : r_acc;

    // Shift-add: add multiplicand into the high half, shift right
    assign w_sum = {1'b0, w_acc[2*W-1:W]}
                 + (w_acc[0] ? {1'b0, w_mag_a} : {(W+1){1'b0}});
    assign w_mul_nxt = {w_sum, w_acc[W-1:1]};

    // Restoring divide: {rem, quo} shifts left, trial subtract
    assign w_rs = w_acc[2*W-1:W-1];
    assign w_ge = (w_rs >= {1'b0, w_mag_b});
    assign w_div_nxt = w_ge
                     ? {w_rs[W-1:0] - w_mag_b, w_acc[W-2:0], 1'b1}
                     : {w_acc[2*W-2:0], 1'b0};

    assign w_acc_nxt = w_is_div ? w_div_nxt : w_mul_nxt;

    // Sign fix-up on the final accumulator value
    assign w_prod = (w_neg_a ^ w_neg_b) ? -w_acc_nxt : w_acc_nxt;
    assign w_quo  = (w_neg_a ^ w_neg_b) ? -w_acc_nxt[W-1:0]
                                        : w_acc_nxt[W-1:0];
    assign w_rem  = w_neg_a ? -w_acc_nxt[2*W-1:W]
                            : w_acc_nxt[2*W-1:W];

    // Divide by zero overrides; signed overflow falls out naturally
    // (magnitude 2^(W-1) / 1, negated, is the most negative value).
    always_comb begin
        w_result = '0;
        case (r_op)
            F_MUL:                     w_result = w_prod[W-1:0];
            F_MULH, F_MULHSU, F_MULHU: w_result = w_prod[2*W-1:W];
            F_DIV, F_DIVU:             w_result = w_b_zero ? '1 : w_quo;
            F_REM, F_REMU:             w_result = w_b_zero ? r_a : w_rem;
            default:                   w_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_CALC;
            S_CALC: if (r_cnt == LAST) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latches, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wen   <= 1'b0;
            r_addrD <= '0;
            r_dataD <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= funct3;
                        r_a    <= dataA;
                        r_b    <= dataB;
                        r_rd   <= rd;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_done  <= 1'b1;
                        r_wen   <= (r_rd != '0);
                        r_addrD <= r_rd;
                        r_dataD <= w_result;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    r_wen  <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign RegWEn = r_wen;
    assign addrD  = r_addrD;
    assign dataD  = r_dataD;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: vector table plus
// hand-written sequences for the multi-cycle corner cases.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic [4:0]  rd = '0;
    logic        busy;
    logic        done;
    logic        RegWEn;
    logic [4:0]  addrD;
    logic [31:0] dataD;

    int n_err = 0;
    int n_chk = 0;

    muldiv_unit #(
        .REG_WIDTH      (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .dataA  (dataA),
        .dataB  (dataB),
        .rd     (rd),
        .busy   (busy),
        .done   (done),
        .RegWEn (RegWEn),
        .addrD  (addrD),
        .dataD  (dataD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  r;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Returns edges counted until done is seen (99 on timeout)
    task automatic wait_done(output int lat);
        lat = 99;
        for (int k = 1; k <= 40 && lat == 99; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int    lat;
        string s;
        s = $sformatf("v%0d", idx);
        @(negedge clk);
        start  = 1'b1;
        funct3 = v.f;
        dataA  = v.a;
        dataB  = v.b;
        rd     = v.r;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = ~v.f;
        dataA  = ~v.a;
        dataB  = $urandom;
        rd     = ~v.r;
        chk({s, "_busy_acc"}, 64'(busy), 64'd1);
        wait_done(lat);
        chk({s, "_latency"}, 64'(lat), 64'd32);
        chk({s, "_dataD"}, 64'(dataD), 64'(v.exp));
        chk({s, "_wen"}, 64'(RegWEn), 64'(v.r != 5'd0));
        chk({s, "_addrD"}, 64'(addrD), 64'(v.r));
        chk({s, "_busy_done"}, 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk({s, "_done_drop"}, 64'(done), 64'd0);
        chk({s, "_wen_drop"}, 64'(RegWEn), 64'd0);
        chk({s, "_busy_drop"}, 64'(busy), 64'd0);
        chk({s, "_dataD_hold"}, 64'(dataD), 64'(v.exp));
    endtask

    initial begin
        int   lat;
        int   pulses;
        vec_t v;

        tbl[0]  = '{f:3'd0, a:32'd7, b:32'hFFFFFFFD,
                    r:5'd5, exp:32'hFFFFFFEB};
        tbl[1]  = '{f:3'd1, a:32'h80000000, b:32'h80000000,
                    r:5'd1, exp:32'h40000000};
        tbl[2]  = '{f:3'd3, a:32'hFFFFFFFF, b:32'hFFFFFFFF,
                    r:5'd2, exp:32'hFFFFFFFE};
        tbl[3]  = '{f:3'd2, a:32'hFFFFFFFF, b:32'd2,
                    r:5'd3, exp:32'hFFFFFFFF};
        tbl[4]  = '{f:3'd4, a:32'hFFFFFFF9, b:32'd2,
                    r:5'd4, exp:32'hFFFFFFFD};
        tbl[5]  = '{f:3'd6, a:32'hFFFFFFF9, b:32'd2,
                    r:5'd6, exp:32'hFFFFFFFF};
        tbl[6]  = '{f:3'd5, a:32'd100, b:32'd7,
                    r:5'd7, exp:32'd14};
        tbl[7]  = '{f:3'd7, a:32'd100, b:32'd7,
                    r:5'd8, exp:32'd2};
        tbl[8]  = '{f:3'd5, a:32'd10, b:32'd0,
                    r:5'd9, exp:32'hFFFFFFFF};
        tbl[9]  = '{f:3'd6, a:32'd10, b:32'd0,
                    r:5'd10, exp:32'd10};
        tbl[10] = '{f:3'd4, a:32'h80000000, b:32'hFFFFFFFF,
                    r:5'd11, exp:32'h80000000};
        tbl[11] = '{f:3'd6, a:32'h80000000, b:32'hFFFFFFFF,
                    r:5'd12, exp:32'd0};
        tbl[12] = '{f:3'd0, a:32'd3, b:32'd4,
                    r:5'd0, exp:32'd12};
        tbl[13] = '{f:3'd0, a:32'hFFFFFFFF, b:32'hFFFFFFFF,
                    r:5'd13, exp:32'd1};
        tbl[14] = '{f:3'd1, a:32'hFFFFFFFF, b:32'hFFFFFFFF,
                    r:5'd14, exp:32'd0};
        tbl[15] = '{f:3'd2, a:32'h80000000, b:32'hFFFFFFFF,
                    r:5'd15, exp:32'h80000000};
        tbl[16] = '{f:3'd3, a:32'h80000000, b:32'hFFFFFFFF,
                    r:5'd16, exp:32'h7FFFFFFF};
        tbl[17] = '{f:3'd4, a:32'hFFFFFF9C, b:32'd7,
                    r:5'd17, exp:32'hFFFFFFF2};
        tbl[18] = '{f:3'd6, a:32'hFFFFFF9C, b:32'd7,
                    r:5'd18, exp:32'hFFFFFFFE};
        tbl[19] = '{f:3'd4, a:32'hFFFFFFF9, b:32'd0,
                    r:5'd19, exp:32'hFFFFFFFF};
        tbl[20] = '{f:3'd6, a:32'hFFFFFFF9, b:32'd0,
                    r:5'd20, exp:32'hFFFFFFF9};
        tbl[21] = '{f:3'd7, a:32'd7, b:32'd0,
                    r:5'd31, exp:32'd7};

        // Reset state, applied between clock edges
        #3;
        reset = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wen", 64'(RegWEn), 64'd0);
        chk("rst_addrD", 64'(addrD), 64'd0);
        chk("rst_dataD", 64'(dataD), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i], i);
        end

        // Start pulsed mid-CALC is ignored
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd5;
        dataA  = 32'd1000;
        dataB  = 32'd3;
        rd     = 5'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 99;
        for (int k = 1; k <= 40 && lat == 99; k++) begin
            start  = (k == 6);
            funct3 = 3'd0;
            dataA  = 32'd2;
            dataB  = 32'd2;
            rd     = 5'd3;
            @(posedge clk);
            #1;
            if (done) lat = k;
        end
        start = 1'b0;
        chk("mid_latency", 64'(lat), 64'd32);
        chk("mid_dataD", 64'(dataD), 64'd333);
        chk("mid_addrD", 64'(addrD), 64'd9);
        @(posedge clk);
        #1;
        chk("mid_busy_after", 64'(busy), 64'd0);

        // Start during DONE is ignored, taken on the next IDLE cycle
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd7;
        dataA  = 32'd100;
        dataB  = 32'd7;
        rd     = 5'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        chk("dn_lat1", 64'(lat), 64'd32);
        chk("dn_data1", 64'(dataD), 64'd2);
        start  = 1'b1;
        funct3 = 3'd0;
        dataA  = 32'd6;
        dataB  = 32'd7;
        rd     = 5'd11;
        @(posedge clk);
        #1;
        chk("dn_ignored", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("dn_accept", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(lat);
        chk("dn_lat2", 64'(lat), 64'd32);
        chk("dn_data2", 64'(dataD), 64'd42);
        chk("dn_addr2", 64'(addrD), 64'd11);
        chk("dn_wen2", 64'(RegWEn), 64'd1);
        @(posedge clk);
        #1;

        // Reset at edge N+10 aborts the operation
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd4;
        dataA  = 32'd50;
        dataB  = 32'd5;
        rd     = 5'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        chk("ar_wen", 64'(RegWEn), 64'd0);
        chk("ar_dataD", 64'(dataD), 64'd0);
        chk("ar_addrD", 64'(addrD), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (RegWEn || done || busy) pulses++;
        end
        chk("ar_no_pulse", 64'(pulses), 64'd0);
        v = '{f:3'd5, a:32'd50, b:32'd5, r:5'd7, exp:32'd10};
        run_op(v, 99);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
